// File: rtl/spi_word_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : spi_word_controller_if
//  Purpose  : Host-side request/response bundle for the 64-bit SPI word
//             controller. The requester uses the master view; the
//             controller uses the slave view.
//  Revision : 1.0 - initial release
// ============================================================================
interface spi_word_controller_if;
  logic        start;
  logic [63:0] tx_word;
  logic        busy;
  logic        done;
  logic [63:0] rx_word;

  modport master (
    output start,
    output tx_word,
    input  busy,
    input  done,
    input  rx_word
  );

  modport slave (
    input  start,
    input  tx_word,
    output busy,
    output done,
    output rx_word
  );
endinterface
`default_nettype wire

// File: rtl/spi_word_controller.sv
`default_nettype none
// ============================================================================
//  Module   : spi_word_controller
//  Purpose  : SPI Mode 0 initiator moving one 64-bit word per transfer.
//             Bytes go least-significant first, bits MSB first in each byte;
//             the received word is assembled in the same order.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_word_controller #(
  parameter int CLK_DIV = 4,  // SCK half-period in clk cycles (2..65535)
  parameter int CS_GAP  = 4   // minimum CS-high cycles between transfers
) (
  input  wire logic             clk,
  input  wire logic             reset,
  spi_word_controller_if.slave  host,
  output logic                  SCK,
  output logic                  CS,
  output logic                  COPI,
  input  wire logic             CIPO
);

  localparam logic [15:0] C_DIV_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] C_GAP_LAST = 16'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SCK_HIGH = 3'd2,
    SCK_LOW  = 3'd3,
    HOLD     = 3'd4,
    GAP      = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic        hold_ph_q, hold_ph_d;
  logic [63:0] tx_q, tx_d;
  logic [63:0] rx_sh_q, rx_sh_d;
  logic [63:0] rx_word_q, rx_word_d;
  logic        cs_q, cs_d;
  logic        sck_q, sck_d;
  logic        copi_q, copi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        w_div_end;
  logic [5:0]  w_bit_next;

  // Serial position k maps to word bit {k[5:3], 7-k[2:0]}: byte k/8, MSB first.
  function automatic logic [5:0] word_idx(input logic [5:0] k);
    return {k[5:3], ~k[2:0]};
  endfunction

  assign w_div_end  = (cnt_q == C_DIV_LAST);
  assign w_bit_next = bit_q + 6'd1;

  // Next-state and output computation for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    hold_ph_d = hold_ph_q;
    tx_d      = tx_q;
    rx_sh_d   = rx_sh_q;
    rx_word_d = rx_word_q;
    cs_d      = cs_q;
    sck_d     = sck_q;
    copi_d    = copi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (host.start) begin
          tx_d    = host.tx_word;
          cs_d    = 1'b0;
          copi_d  = host.tx_word[7];  // serial bit 0
          busy_d  = 1'b1;
          cnt_d   = 16'd0;
          bit_d   = 6'd0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (w_div_end) begin
          cnt_d   = 16'd0;
          sck_d   = 1'b1;
          rx_sh_d[word_idx(bit_q)] = CIPO;
          state_d = SCK_HIGH;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      SCK_HIGH: begin
        if (w_div_end) begin
          cnt_d = 16'd0;
          sck_d = 1'b0;
          if (bit_q != 6'd63) begin
            copi_d  = tx_q[word_idx(w_bit_next)];
            state_d = SCK_LOW;
          end else begin
            bit_d     = w_bit_next;  // wraps 63 -> 0
            hold_ph_d = 1'b0;
            state_d   = HOLD;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      SCK_LOW: begin
        if (w_div_end) begin
          cnt_d   = 16'd0;
          sck_d   = 1'b1;
          bit_d   = w_bit_next;
          rx_sh_d[word_idx(w_bit_next)] = CIPO;
          state_d = SCK_HIGH;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // HOLD spans the trailing SCK-low half period and then the CS hold
      // half period, so CS stays low for 130 half periods in total.
      HOLD: begin
        if (w_div_end) begin
          cnt_d = 16'd0;
          if (!hold_ph_q) begin
            hold_ph_d = 1'b1;
          end else begin
            hold_ph_d = 1'b0;
            cs_d      = 1'b1;
            copi_d    = 1'b0;
            rx_word_d = rx_sh_q;
            done_d    = 1'b1;
            state_d   = GAP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      GAP: begin
        if (cnt_q == C_GAP_LAST) begin
          cnt_d   = 16'd0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transfer at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      bit_q     <= 6'd0;
      hold_ph_q <= 1'b0;
      tx_q      <= 64'd0;
      rx_sh_q   <= 64'd0;
      rx_word_q <= 64'd0;
      cs_q      <= 1'b1;
      sck_q     <= 1'b0;
      copi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      hold_ph_q <= hold_ph_d;
      tx_q      <= tx_d;
      rx_sh_q   <= rx_sh_d;
      rx_word_q <= rx_word_d;
      cs_q      <= cs_d;
      sck_q     <= sck_d;
      copi_q    <= copi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign SCK          = sck_q;
  assign CS           = cs_q;
  assign COPI         = copi_q;
  assign host.busy    = busy_q;
  assign host.done    = done_q;
  assign host.rx_word = rx_word_q;

endmodule
`default_nettype wire
